// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, PC step and FSM encodings.
package ifetch_queue_pkg;

  localparam int WORD_W  = 64;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_RUN   = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Prefetch FIFO holding {instruction, address} pairs; clear wins over push and pop.
module ifetch_queue_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic [DW-1:0] head_data_o,
  output logic [AW-1:0] head_addr_o
);

  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= push_i ? wr_q + PW'(1) : wr_q;
      rd_q    <= do_pop ? rd_q + PW'(1) : rd_q;
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      data_q[wr_q] <= push_data_i;
      addr_q[wr_q] <= push_addr_i;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[rd_q];
  assign head_addr_o = addr_q[rd_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited word fetches, prefetch FIFO, branch redirect with stale drop.
// Defining FETCH_STATS_EN adds saturating stat_fetched / stat_flushed counter outputs.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int              WORD        = WORD_W,
  parameter int              INSTR_LEN   = INSTR_W,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [WORD-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] Instruction,
  output logic [WORD-1:0]      PC,
  output logic [WORD-1:0]      nPC,
  input  logic                 branch_taken,
  input  logic [WORD-1:0]      branch_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_flushed
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  if_state_e            state_q, state_d;
  logic [WORD-1:0]      fetch_pc_q, fetch_pc_d, push_pc_q, push_pc_d, target;
  logic [CW-1:0]        outst_q, outst_d, drop_q, drop_d, fifo_count, count_d;
  logic                 req_valid_q, req_valid_d;
  logic                 req_hs, rsp_drop, push, pop, credit_ok;
  logic [INSTR_LEN-1:0] head_data;
  logic [WORD-1:0]      head_addr;

  assign target      = branch_target & ~WORD'(3);
  assign instr_valid = (fifo_count != '0);

  // Next-state: every response during a redirect or while drop_q is non-zero is stale.
  always_comb begin
    req_hs     = req_valid_q & imem_req_ready;
    rsp_drop   = imem_rsp_valid & (branch_taken | (drop_q != '0));
    push       = imem_rsp_valid & ~rsp_drop;
    pop        = instr_valid & instr_ready & ~branch_taken;
    outst_d    = outst_q + CW'(req_hs) - CW'(imem_rsp_valid);
    count_d    = branch_taken ? '0 : fifo_count + CW'(push) - CW'(pop);
    if (branch_taken) begin
      fetch_pc_d = target;
      push_pc_d  = target;
      drop_d     = outst_d;
    end else begin
      fetch_pc_d = req_hs   ? fetch_pc_q + WORD'(PC_INC) : fetch_pc_q;
      push_pc_d  = push     ? push_pc_q + WORD'(PC_INC)  : push_pc_q;
      drop_d     = rsp_drop ? drop_q - CW'(1)            : drop_q;
    end
    case (state_q)
      IF_IDLE:  state_d = IF_RUN;
      IF_RUN:   state_d = (branch_taken && outst_d != '0) ? IF_FLUSH : IF_RUN;
      IF_FLUSH: state_d = (!branch_taken && drop_d == '0) ? IF_RUN : IF_FLUSH;
      default:  state_d = IF_IDLE;
    endcase
    credit_ok = ({1'b0, count_d} + {1'b0, outst_d}) < (CW+1)'(QUEUE_DEPTH);
    if (branch_taken) begin
      req_valid_d = 1'b0;
    end else if (req_valid_q && !imem_req_ready) begin
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = (state_d == IF_RUN) && credit_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IF_IDLE;
      fetch_pc_q  <= RESET_PC;
      push_pc_q   <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      push_pc_q   <= push_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
    end
  end

  ifetch_queue_fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .DW    (INSTR_LEN),
    .AW    (WORD)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push),
    .push_data_i (imem_rsp_data),
    .push_addr_i (push_pc_q),
    .pop_i       (pop),
    .clear_i     (branch_taken),
    .count_o     (fifo_count),
    .head_data_o (head_data),
    .head_addr_o (head_addr)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign Instruction    = instr_valid ? head_data : '0;
  assign PC             = instr_valid ? head_addr : '0;
  assign nPC            = instr_valid ? head_addr + WORD'(PC_INC) : '0;

`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetched_q, stat_flushed_q;
  logic [CW-1:0] flush_inc;

  assign flush_inc = (branch_taken ? fifo_count : '0) + CW'(rsp_drop);

  // Discarded work = FIFO entries cleared by a redirect plus every dropped response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= 32'd0;
      stat_flushed_q <= 32'd0;
    end else begin
      stat_fetched_q <= sat_add32(stat_fetched_q, 32'(pop));
      stat_flushed_q <= sat_add32(stat_flushed_q, 32'(flush_inc));
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model with fixed latency plus an address-stream reference model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] Instruction;
  logic [63:0] PC;
  logic [63:0] nPC;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  ifetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instruction    (Instruction),
    .PC             (PC),
    .nPC            (nPC),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] addr; } mreq_t;
  mreq_t       mq[$];
  logic [63:0] hs_addr[$];
  logic [63:0] pop_pc[$];
  logic [63:0] pop_npc[$];
  int          passed = 0, total = 0;
  int          cyc = 0, lat = 1, hs_cnt = 0, pops = 0, rsp_sent = 0;
  int          first_hs = -1, first_valid = -1, n0 = 0, h1 = 0;
  logic [63:0] exp_fetch, exp_pop;
  logic        prev_branch = 1'b0, prev_pending = 1'b0;

  function automatic logic [31:0] mfn(input logic [63:0] a);
    return a[31:0] ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic chk_pop(input string name, input int i, input logic [63:0] e);
    if (i < pop_pc.size()) chk(name, pop_pc[i], e);
    else chk({name, "_missing"}, 64'(pop_pc.size()), 64'(i + 1));
  endtask

  task automatic chk_npc(input string name, input int i, input logic [63:0] e);
    if (i < pop_npc.size()) chk(name, pop_npc[i], e);
    else chk({name, "_missing"}, 64'(pop_npc.size()), 64'(i + 1));
  endtask

  task automatic chk_hs(input string name, input int i, input logic [63:0] e);
    if (i < hs_addr.size()) chk(name, hs_addr[i], e);
    else chk({name, "_missing"}, 64'(hs_addr.size()), 64'(i + 1));
  endtask

  // One clock cycle: drive memory, check outputs, advance the reference model.
  task automatic cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mfn(mq[0].addr);
      void'(mq.pop_front());
      rsp_sent++;
    end
    #1;
    if (instr_valid) begin
      if (first_valid < 0) first_valid = cyc;
      chk("npc_rule", nPC, PC + 64'd4);
      chk("instr_data", 64'(Instruction), 64'(mfn(PC)));
      if (instr_ready && !branch_taken) begin
        chk("pop_pc", PC, exp_pop);
        exp_pop = exp_pop + 64'd4;
        pop_pc.push_back(PC);
        pop_npc.push_back(nPC);
        pops++;
      end
    end else begin
      chk("empty_outputs", {32'h0, Instruction} | PC | nPC, 64'h0);
    end
    if (prev_branch) chk("withdraw_after_redirect", 64'(imem_req_valid), 64'd0);
    else if (prev_pending) chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
    if (imem_req_valid && imem_req_ready) begin
      if (first_hs < 0) first_hs = cyc;
      hs_addr.push_back(imem_req_addr);
      mq.push_back('{due: cyc + lat, addr: imem_req_addr});
      exp_fetch = exp_fetch + 64'd4;
      hs_cnt++;
    end
    chk("credit", 64'(mq.size() <= DEPTH), 64'd1);
    prev_pending = imem_req_valid && !imem_req_ready;
    prev_branch  = branch_taken;
    if (branch_taken) begin
      exp_fetch = branch_target & ~64'd3;
      exp_pop   = branch_target & ~64'd3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    branch_taken   = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_outputs", {32'h0, Instruction} | PC | nPC, 64'h0);
    mq.delete(); hs_addr.delete(); pop_pc.delete(); pop_npc.delete();
    exp_fetch = RESET_PC; exp_pop = RESET_PC;
    prev_branch = 1'b0; prev_pending = 1'b0;
    hs_cnt = 0; pops = 0; rsp_sent = 0; first_hs = -1; first_valid = -1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    @(negedge clk);
    // Streaming with latency 1 and everything ready.
    lat = 1; instr_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    run(12);
    chk("first_valid_latency", 64'(first_valid - first_hs), 64'd2);
    chk_pop("a_pc0", 0, 64'h0);  chk_pop("a_pc1", 1, 64'h4);
    chk_pop("a_pc2", 2, 64'h8);  chk_pop("a_pc3", 3, 64'hC);
    chk_npc("a_npc0", 0, 64'h4); chk_npc("a_npc3", 3, 64'h10);

    // Mid-stream reset, then decode stalled: credits allow exactly DEPTH requests.
    do_reset();
    instr_ready = 1'b0;
    run(12);
    chk("stall_hs_count", 64'(hs_cnt), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    instr_ready = 1'b1;
    run(10);
    chk_pop("b_pc0", 0, 64'h0); chk_pop("b_pc3", 3, 64'hC);
    chk_hs("b_resume_addr", 4, 64'h10);

    // Memory not ready for 3 cycles while the request at 0x8 is pending.
    do_reset();
    for (int i = 0; i < 20 && hs_cnt < 2; i++) cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(imem_req_valid), 64'd1);
      chk("hold_addr", imem_req_addr, 64'h8);
      cycle();
    end
    imem_req_ready = 1'b1;
    run(6);
    chk_hs("c_addr2", 2, 64'h8); chk_hs("c_addr3", 3, 64'hC);

    // Latency 3, redirect to 0x40 with two requests outstanding.
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && hs_cnt < 2; i++) cycle();
    imem_req_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h40;
    n0 = pop_pc.size();
    cycle();
    branch_taken = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 40 && pop_pc.size() == n0; i++) cycle();
    chk_pop("d_first_pc", n0, 64'h40);
    chk_npc("d_first_npc", n0, 64'h44);

    // Misaligned target 0x103 redirects fetch to 0x100.
    run(6);
    branch_taken = 1'b1; branch_target = 64'h103;
    cycle();
    branch_taken = 1'b0;
    h1 = hs_addr.size(); n0 = pop_pc.size();
    for (int i = 0; i < 40 && pop_pc.size() == n0; i++) cycle();
    chk_hs("e_first_req", h1, 64'h100);
    chk_pop("e_first_pc", n0, 64'h100);

    // Second redirect while still flushing: only the 0x200 stream survives.
    run(2);
    branch_taken = 1'b1; branch_target = 64'h180;
    cycle();
    branch_target = 64'h200;
    cycle();
    branch_taken = 1'b0;
    h1 = hs_addr.size(); n0 = pop_pc.size();
    for (int i = 0; i < 40 && pop_pc.size() <= n0 + 1; i++) cycle();
    chk_hs("e2_first_req", h1, 64'h200);
    chk_pop("e2_first_pc", n0, 64'h200);
    chk_pop("e2_second_pc", n0 + 1, 64'h204);

    // Drain: nothing in flight and the FIFO empty.
    imem_req_ready = 1'b0;
    run(10);
`ifdef FETCH_STATS_EN
    chk("stat_fetched", 64'(stat_fetched), 64'(pops));
    chk("stat_flushed", 64'(stat_flushed), 64'(rsp_sent - pops));
`endif

    // Reset during streaming restarts at RESET_PC.
    imem_req_ready = 1'b1;
    run(4);
    lat = 1;
    do_reset();
    run(5);
    chk_hs("restart_addr", 0, RESET_PC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
